// File: rtl/imc_pkg.sv
// Shared definitions for the IMC array sequencer: op codes, FSM states
// and default phase timing.
package imc_pkg;

  typedef enum logic [1:0] {
    OP_WRITE   = 2'b00,
    OP_READ    = 2'b01,
    OP_COMPUTE = 2'b10,
    OP_ILLEGAL = 2'b11
  } imc_op_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRECH = 3'd1,
    ST_GAP   = 3'd2,
    ST_WL    = 3'd3,
    ST_EVAL  = 3'd4,
    ST_SENSE = 3'd5,
    ST_CONV  = 3'd6,
    ST_RESP  = 3'd7
  } imc_state_e;

  localparam int unsigned DEF_ROWS     = 16;
  localparam int unsigned DEF_COLS     = 16;
  localparam int unsigned DEF_ADC_BITS = 4;
  localparam int unsigned DEF_T_PRE    = 2;
  localparam int unsigned DEF_T_WL     = 2;
  localparam int unsigned DEF_T_SA     = 1;
  localparam int unsigned DEF_T_ADC    = 4;

  function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                       input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/imc_array_sequencer_checker.sv
// Safety properties on the array pins: write/read wordline exclusion and
// break-before-make between precharge and any wordline.
module imc_array_sequencer_checker #(
  parameter int unsigned ROWS = 16
) (
  input logic            clk,
  input logic            reset_n,
  input logic            pre_any,
  input logic [ROWS-1:0] wwl,
  input logic [ROWS-1:0] rwl,
  input logic [ROWS-1:0] rwlb
);

  // Registered pins are checked once per cycle outside reset.
  always @(posedge clk) begin
    if (reset_n) begin
      assert (!((|wwl) && (|rwl)));
      assert ($onehot0(wwl));
      assert (!(pre_any && ((|wwl) || (|rwl) || (|rwlb))));
    end
  end

endmodule

// File: rtl/imc_phase_timer.sv
// Loadable down-counter timing one sequencer phase; done marks the last
// cycle of the phase.
module imc_phase_timer #(
  parameter int unsigned W = 3
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt_r;

  // Load on phase entry, then count down and park at zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r <= '0;
    end else if (load) begin
      cnt_r <= load_val;
    end else if (cnt_r != '0) begin
      cnt_r <= cnt_r - W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign done = (cnt_r == W'(1));

endmodule

// File: rtl/imc_array_sequencer.sv
// Command sequencer for the 16x16 SRAM in-memory-compute macro: walks the
// precharge / wordline / sense / ADC phases and returns a held response.
module imc_array_sequencer
  import imc_pkg::*;
#(
  parameter int unsigned ROWS     = DEF_ROWS,
  parameter int unsigned COLS     = DEF_COLS,
  parameter int unsigned ADC_BITS = DEF_ADC_BITS,
  parameter int unsigned T_PRE    = DEF_T_PRE,
  parameter int unsigned T_WL     = DEF_T_WL,
  parameter int unsigned T_SA     = DEF_T_SA,
  parameter int unsigned T_ADC    = DEF_T_ADC,
  localparam int unsigned RW      = $clog2(ROWS)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [1:0]               cmd_op,
  input  logic [RW-1:0]            cmd_row,
  input  logic [COLS-1:0]          cmd_wdata,
  input  logic [ROWS-1:0]          cmd_ivec,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic                     rsp_err,
  output logic [COLS-1:0]          rsp_rdata,
  output logic [COLS*ADC_BITS-1:0] rsp_mac,
  output logic                     busy,
  output logic                     PRE_SRAM,
  output logic                     PRE_VLSA,
  output logic                     PRE_CLSA,
  output logic                     PRE_A,
  output logic                     WE,
  output logic                     EN,
  output logic                     SAEN,
  output logic [ROWS-1:0]          WWL,
  output logic [ROWS-1:0]          RWL,
  output logic [ROWS-1:0]          RWLB,
  output logic [COLS-1:0]          Din,
  input  logic [COLS-1:0]          SA_OUT,
  input  logic [COLS*ADC_BITS-1:0] ADC_OUT
);

  localparam int unsigned TW = $clog2(max4(T_PRE, T_WL, T_SA, T_ADC)) + 1;

  imc_state_e state_r, state_s;
  imc_op_e    op_r, op_s;
  logic [RW-1:0]   row_r, row_s;
  logic [COLS-1:0] wdata_r, wdata_s;
  logic [ROWS-1:0] ivec_r, ivec_s;
  logic            err_r, err_s;
  logic            accept_s, illegal_s, done_s, load_s;
  logic [TW-1:0]   load_val_s;
  logic [ROWS-1:0] onehot_s;

  logic cmd_ready_r, busy_r, rsp_valid_r, rsp_err_r;
  logic pre_sram_r, pre_vlsa_r, pre_clsa_r, pre_a_r, we_r, en_r, saen_r;
  logic [ROWS-1:0] wwl_r, rwl_r, rwlb_r;
  logic [COLS-1:0] din_r, rsp_rdata_r;
  logic [COLS*ADC_BITS-1:0] rsp_mac_r;

  logic cmd_ready_s, busy_s, rsp_valid_s;
  logic pre_sram_s, pre_vlsa_s, pre_clsa_s, pre_a_s, we_s, en_s, saen_s;
  logic [ROWS-1:0] wwl_s, rwl_s, rwlb_s;
  logic [COLS-1:0] din_s;

  assign accept_s  = cmd_valid & cmd_ready_r;
  assign illegal_s = (cmd_op == OP_ILLEGAL) || (32'(cmd_row) >= ROWS);

  // Command fields as they will stand after this edge.
  always_comb begin
    if (accept_s) begin
      op_s    = imc_op_e'(cmd_op);
      row_s   = cmd_row;
      wdata_s = cmd_wdata;
      ivec_s  = cmd_ivec;
      err_s   = illegal_s;
    end else begin
      op_s    = op_r;
      row_s   = row_r;
      wdata_s = wdata_r;
      ivec_s  = ivec_r;
      err_s   = err_r;
    end
  end

  // Row decoder for the single-row wordline phases.
  always_comb begin
    onehot_s = '0;
    onehot_s[row_s] = 1'b1;
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE:  if (accept_s) state_s = illegal_s ? ST_GAP : ST_PRECH;
                else          state_s = ST_IDLE;
      ST_PRECH: if (done_s) state_s = ST_GAP;
                else        state_s = ST_PRECH;
      ST_GAP:   if (!done_s)                  state_s = ST_GAP;
                else if (err_r)               state_s = ST_RESP;
                else if (op_r == OP_COMPUTE)  state_s = ST_EVAL;
                else                          state_s = ST_WL;
      ST_WL:    if (!done_s)                  state_s = ST_WL;
                else if (op_r == OP_WRITE)    state_s = ST_RESP;
                else                          state_s = ST_SENSE;
      ST_EVAL:  if (done_s) state_s = ST_CONV;
                else        state_s = ST_EVAL;
      ST_SENSE: if (done_s) state_s = ST_RESP;
                else        state_s = ST_SENSE;
      ST_CONV:  if (done_s) state_s = ST_RESP;
                else        state_s = ST_CONV;
      ST_RESP:  if (rsp_ready) state_s = ST_IDLE;
                else           state_s = ST_RESP;
      default:  state_s = ST_IDLE;
    endcase
  end

  // Phase length for the state being entered.
  always_comb begin
    load_s = (state_s != state_r);
    case (state_s)
      ST_PRECH:        load_val_s = TW'(T_PRE);
      ST_WL, ST_EVAL:  load_val_s = TW'(T_WL);
      ST_SENSE:        load_val_s = TW'(T_SA);
      ST_CONV:         load_val_s = TW'(T_ADC);
      default:         load_val_s = TW'(1);
    endcase
  end

  imc_phase_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (load_s),
    .load_val (load_val_s),
    .done     (done_s)
  );

  // Pin values for the state being entered, so the pins can be registered.
  always_comb begin
    cmd_ready_s = 1'b0;
    busy_s      = (state_s != ST_IDLE);
    rsp_valid_s = 1'b0;
    pre_sram_s  = 1'b0;
    pre_vlsa_s  = 1'b0;
    pre_clsa_s  = 1'b0;
    pre_a_s     = 1'b0;
    we_s        = 1'b0;
    en_s        = 1'b0;
    saen_s      = 1'b0;
    wwl_s       = '0;
    rwl_s       = '0;
    rwlb_s      = '0;
    din_s       = '0;
    case (state_s)
      ST_IDLE:  cmd_ready_s = 1'b1;
      ST_PRECH: begin
        pre_sram_s = 1'b1;
        pre_vlsa_s = (op_s == OP_READ);
        pre_clsa_s = (op_s == OP_READ);
        pre_a_s    = (op_s == OP_COMPUTE);
      end
      ST_WL: begin
        if (op_s == OP_WRITE) begin
          wwl_s = onehot_s;
          we_s  = 1'b1;
          din_s = wdata_s;
        end else begin
          rwl_s = onehot_s;
        end
      end
      ST_SENSE: begin
        rwl_s  = onehot_s;
        saen_s = 1'b1;
      end
      ST_EVAL, ST_CONV: begin
        rwl_s  = ivec_s;
        rwlb_s = ~ivec_s;
        en_s   = 1'b1;
      end
      ST_RESP:  rsp_valid_s = 1'b1;
      default:  cmd_ready_s = 1'b0;
    endcase
  end

  // State, latched command and registered array pins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= ST_IDLE;
      op_r        <= OP_WRITE;
      row_r       <= '0;
      wdata_r     <= '0;
      ivec_r      <= '0;
      err_r       <= 1'b0;
      cmd_ready_r <= 1'b1;
      busy_r      <= 1'b0;
      rsp_valid_r <= 1'b0;
      pre_sram_r  <= 1'b0;
      pre_vlsa_r  <= 1'b0;
      pre_clsa_r  <= 1'b0;
      pre_a_r     <= 1'b0;
      we_r        <= 1'b0;
      en_r        <= 1'b0;
      saen_r      <= 1'b0;
      wwl_r       <= '0;
      rwl_r       <= '0;
      rwlb_r      <= '0;
      din_r       <= '0;
    end else begin
      state_r     <= state_s;
      op_r        <= op_s;
      row_r       <= row_s;
      wdata_r     <= wdata_s;
      ivec_r      <= ivec_s;
      err_r       <= err_s;
      cmd_ready_r <= cmd_ready_s;
      busy_r      <= busy_s;
      rsp_valid_r <= rsp_valid_s;
      pre_sram_r  <= pre_sram_s;
      pre_vlsa_r  <= pre_vlsa_s;
      pre_clsa_r  <= pre_clsa_s;
      pre_a_r     <= pre_a_s;
      we_r        <= we_s;
      en_r        <= en_s;
      saen_r      <= saen_s;
      wwl_r       <= wwl_s;
      rwl_r       <= rwl_s;
      rwlb_r      <= rwlb_s;
      din_r       <= din_s;
    end
  end

  // Response payload changes only on RESP entry so it holds while rsp_valid.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_err_r   <= 1'b0;
      rsp_rdata_r <= '0;
      rsp_mac_r   <= '0;
    end else if ((state_s == ST_RESP) && (state_r != ST_RESP)) begin
      rsp_err_r   <= err_r;
      rsp_rdata_r <= (state_r == ST_SENSE) ? SA_OUT : '0;
      rsp_mac_r   <= (state_r == ST_CONV) ? ADC_OUT : '0;
    end else begin
      rsp_err_r   <= rsp_err_r;
      rsp_rdata_r <= rsp_rdata_r;
      rsp_mac_r   <= rsp_mac_r;
    end
  end

  assign cmd_ready = cmd_ready_r;
  assign busy      = busy_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_err   = rsp_err_r;
  assign rsp_rdata = rsp_rdata_r;
  assign rsp_mac   = rsp_mac_r;
  assign PRE_SRAM  = pre_sram_r;
  assign PRE_VLSA  = pre_vlsa_r;
  assign PRE_CLSA  = pre_clsa_r;
  assign PRE_A     = pre_a_r;
  assign WE        = we_r;
  assign EN        = en_r;
  assign SAEN      = saen_r;
  assign WWL       = wwl_r;
  assign RWL       = rwl_r;
  assign RWLB      = rwlb_r;
  assign Din       = din_r;

  imc_array_sequencer_checker #(.ROWS(ROWS)) u_checker (
    .clk     (clk),
    .reset_n (reset_n),
    .pre_any (pre_sram_r | pre_vlsa_r | pre_clsa_r | pre_a_r),
    .wwl     (wwl_r),
    .rwl     (rwl_r),
    .rwlb    (rwlb_r)
  );

endmodule

// File: tb/tb_imc_array_sequencer.sv
// Self-checking bench for imc_array_sequencer: a phase-schedule model
// checked every cycle, plus directed commands with literal expectations.
module tb_imc_array_sequencer;

  localparam int T_PRE = 2;
  localparam int T_WL  = 2;
  localparam int T_SA  = 1;
  localparam int T_ADC = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'b00;
  logic [3:0]  cmd_row = 4'd0;
  logic [15:0] cmd_wdata = 16'h0000;
  logic [15:0] cmd_ivec = 16'h0000;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic        rsp_err;
  logic [15:0] rsp_rdata;
  logic [63:0] rsp_mac;
  logic        busy;
  logic        PRE_SRAM, PRE_VLSA, PRE_CLSA, PRE_A, WE, EN, SAEN;
  logic [15:0] WWL, RWL, RWLB, Din;
  logic [15:0] SA_OUT = 16'h0000;
  logic [63:0] ADC_OUT = 64'h0;

  int checks = 0;
  int errors = 0;

  imc_array_sequencer dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_row(cmd_row), .cmd_wdata(cmd_wdata), .cmd_ivec(cmd_ivec),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_err(rsp_err),
    .rsp_rdata(rsp_rdata), .rsp_mac(rsp_mac), .busy(busy),
    .PRE_SRAM(PRE_SRAM), .PRE_VLSA(PRE_VLSA), .PRE_CLSA(PRE_CLSA), .PRE_A(PRE_A),
    .WE(WE), .EN(EN), .SAEN(SAEN), .WWL(WWL), .RWL(RWL), .RWLB(RWLB),
    .Din(Din), .SA_OUT(SA_OUT), .ADC_OUT(ADC_OUT)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int latency(input logic [1:0] op);
    case (op)
      2'b00:   return T_PRE + 1 + T_WL;
      2'b01:   return T_PRE + 1 + T_WL + T_SA;
      2'b10:   return T_PRE + 1 + T_WL + T_ADC;
      default: return 1;
    endcase
  endfunction

  // Model: e counts edges since accept; phases are fixed windows of e.
  bit          m_idle = 1'b1;
  bit          m_resp = 1'b0;
  int          m_e = 0;
  int          m_n = 0;
  logic [1:0]  m_op = 2'b00;
  logic [3:0]  m_row = 4'd0;
  logic [15:0] m_wdata = 16'h0, m_ivec = 16'h0, m_rdata = 16'h0;
  logic [63:0] m_mac = 64'h0;
  logic        m_err = 1'b0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_idle = 1'b1; m_resp = 1'b0; m_e = 0;
    end else if (m_idle) begin
      if (cmd_valid) begin
        m_op = cmd_op; m_row = cmd_row; m_wdata = cmd_wdata; m_ivec = cmd_ivec;
        m_err = (cmd_op == 2'b11);
        m_n = latency(cmd_op);
        m_e = 0; m_idle = 1'b0;
      end
    end else if (m_resp && rsp_ready) begin
      m_idle = 1'b1; m_resp = 1'b0;
    end else begin
      m_e++;
      if (m_e == m_n) begin
        m_resp  = 1'b1;
        m_rdata = (m_op == 2'b01) ? SA_OUT : 16'h0;
        m_mac   = (m_op == 2'b10) ? ADC_OUT : 64'h0;
      end
    end
  end

  // Every-cycle comparison against the model.
  logic        x_pre, x_vlsa, x_clsa, x_prea, x_we, x_en, x_saen;
  logic [15:0] x_wwl, x_rwl, x_rwlb, x_din, x_oh;
  always @(negedge clk) begin
    x_pre = 1'b0; x_vlsa = 1'b0; x_clsa = 1'b0; x_prea = 1'b0;
    x_we = 1'b0; x_en = 1'b0; x_saen = 1'b0;
    x_wwl = 16'h0; x_rwl = 16'h0; x_rwlb = 16'h0; x_din = 16'h0;
    x_oh = 16'h0001 << m_row;
    if (!m_idle && !m_resp && !m_err) begin
      if (m_e < T_PRE) begin
        x_pre = 1'b1;
        x_vlsa = (m_op == 2'b01); x_clsa = (m_op == 2'b01); x_prea = (m_op == 2'b10);
      end else if (m_e == T_PRE) begin
        x_pre = 1'b0;
      end else if (m_e <= T_PRE + T_WL) begin
        if (m_op == 2'b00) begin x_wwl = x_oh; x_we = 1'b1; x_din = m_wdata; end
        else if (m_op == 2'b01) x_rwl = x_oh;
        else begin x_rwl = m_ivec; x_rwlb = ~m_ivec; x_en = 1'b1; end
      end else if (m_op == 2'b01) begin
        x_rwl = x_oh; x_saen = 1'b1;
      end else begin
        x_rwl = m_ivec; x_rwlb = ~m_ivec; x_en = 1'b1;
      end
    end
    chk("m_cmd_ready", cmd_ready, m_idle);
    chk("m_busy", busy, !m_idle);
    chk("m_rsp_valid", rsp_valid, m_resp);
    chk("m_pre_sram", PRE_SRAM, x_pre);
    chk("m_pre_vlsa", PRE_VLSA, x_vlsa);
    chk("m_pre_clsa", PRE_CLSA, x_clsa);
    chk("m_pre_a", PRE_A, x_prea);
    chk("m_we", WE, x_we);
    chk("m_en", EN, x_en);
    chk("m_saen", SAEN, x_saen);
    chk("m_wwl", WWL, x_wwl);
    chk("m_rwl", RWL, x_rwl);
    chk("m_rwlb", RWLB, x_rwlb);
    chk("m_din", Din, x_din);
    if (m_resp) begin
      chk("m_rsp_err", rsp_err, m_err);
      chk("m_rsp_rdata", rsp_rdata, m_rdata);
      chk("m_rsp_mac", rsp_mac, m_mac);
    end
  end

  // One command end to end, called and returning at a negedge.
  task automatic run_cmd(input string tag, input logic [1:0] op, input logic [3:0] row,
                         input logic [15:0] wd, input logic [15:0] iv,
                         input logic [15:0] sa, input logic [63:0] adc,
                         input int hold, input bit hold_valid,
                         input int x_lat, input int x_pre, input int x_en,
                         input int x_saen, input int x_we,
                         input logic [15:0] x_wl, input logic [15:0] x_rwlb,
                         input logic [15:0] x_din, input logic x_err,
                         input logic [15:0] x_rdata, input logic [63:0] x_mac);
    int lat, n_pre, n_en, n_saen, n_we, w;
    logic [15:0] wl_acc, rwlb_acc, din_acc;
    w = 0;
    while (!cmd_ready && w < 50) begin @(negedge clk); w++; end
    chk({tag, "_ready"}, cmd_ready, 1'b1);
    cmd_valid = 1'b1; cmd_op = op; cmd_row = row; cmd_wdata = wd; cmd_ivec = iv;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_op = 2'($urandom); cmd_row = 4'($urandom);
    cmd_wdata = 16'($urandom); cmd_ivec = 16'($urandom);
    lat = -1; n_pre = 0; n_en = 0; n_saen = 0; n_we = 0;
    wl_acc = 16'h0; rwlb_acc = 16'h0; din_acc = 16'h0;
    for (int c = 0; c < 40 && lat < 0; c++) begin
      if (rsp_valid) begin
        lat = c;
      end else begin
        n_pre += int'(PRE_SRAM); n_en += int'(EN); n_saen += int'(SAEN); n_we += int'(WE);
        wl_acc |= (WWL | RWL); rwlb_acc |= RWLB; din_acc |= Din;
        SA_OUT  = (c == x_lat - 1) ? sa : 16'($urandom);
        ADC_OUT = (c == x_lat - 1) ? adc : {$urandom, $urandom};
        @(negedge clk);
      end
    end
    chk({tag, "_latency"}, lat, x_lat);
    chk({tag, "_pre_cycles"}, n_pre, x_pre);
    chk({tag, "_en_cycles"}, n_en, x_en);
    chk({tag, "_saen_cycles"}, n_saen, x_saen);
    chk({tag, "_we_cycles"}, n_we, x_we);
    chk({tag, "_wordlines"}, wl_acc, x_wl);
    chk({tag, "_rwlb"}, rwlb_acc, x_rwlb);
    chk({tag, "_din"}, din_acc, x_din);
    chk({tag, "_err"}, rsp_err, x_err);
    chk({tag, "_rdata"}, rsp_rdata, x_rdata);
    chk({tag, "_mac"}, rsp_mac, x_mac);
    for (int h = 0; h < hold; h++) begin
      if (hold_valid) begin
        cmd_valid = 1'b1; cmd_op = 2'b00; cmd_row = 4'd5; cmd_wdata = 16'h0F0F;
      end
      @(negedge clk);
      chk({tag, "_hold_ready"}, cmd_ready, 1'b0);
      chk({tag, "_hold_rdata"}, rsp_rdata, x_rdata);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    chk({tag, "_hs_ready"}, cmd_ready, 1'b1);
    chk({tag, "_hs_busy"}, busy, 1'b0);
    chk({tag, "_hs_pre"}, PRE_SRAM, 1'b0);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_cmd_ready"}, cmd_ready, 1'b1);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_rsp"}, {rsp_valid, rsp_err}, 2'b00);
    chk({tag, "_rsp_data"}, {rsp_rdata, rsp_mac[47:0]}, 64'h0);
    chk({tag, "_rsp_mac_hi"}, rsp_mac[63:48], 16'h0);
    chk({tag, "_ctrl"}, {PRE_SRAM, PRE_VLSA, PRE_CLSA, PRE_A, WE, EN, SAEN}, 7'h00);
    chk({tag, "_wl"}, {WWL, RWL, RWLB, Din}, 64'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    chk_reset_state("reset");
    reset_n = 1'b1;
    @(negedge clk);

    run_cmd("write_r3", 2'b00, 4'd3, 16'hA5C3, 16'h0, 16'h0, 64'h0, 0, 1'b0,
            5, 2, 0, 0, 2, 16'h0008, 16'h0, 16'hA5C3, 1'b0, 16'h0, 64'h0);
    run_cmd("read_r15", 2'b01, 4'd15, 16'h0, 16'h0, 16'h1234, 64'h0, 0, 1'b0,
            6, 2, 0, 1, 0, 16'h8000, 16'h0, 16'h0, 1'b0, 16'h1234, 64'h0);
    run_cmd("compute_ff", 2'b10, 4'd0, 16'h0, 16'h00FF, 16'h0, 64'h0123_4567_89AB_CDEF,
            0, 1'b0, 9, 2, 6, 0, 0, 16'h00FF, 16'hFF00, 16'h0, 1'b0, 16'h0,
            64'h0123_4567_89AB_CDEF);

    // Asynchronous reset while converting.
    cmd_valid = 1'b1; cmd_op = 2'b10; cmd_ivec = 16'h3C3C;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (6) @(negedge clk);
    chk("conv_en_before_reset", EN, 1'b1);
    #2 reset_n = 1'b0;
    #1 chk_reset_state("midreset");
    @(negedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);

    run_cmd("illegal", 2'b11, 4'd7, 16'hFFFF, 16'hFFFF, 16'h0, 64'h0, 0, 1'b0,
            1, 0, 0, 0, 0, 16'h0, 16'h0, 16'h0, 1'b1, 16'h0, 64'h0);
    run_cmd("read_hold", 2'b01, 4'd0, 16'h0, 16'h0, 16'hBEEF, 64'h0, 10, 1'b1,
            6, 2, 0, 1, 0, 16'h0001, 16'h0, 16'h0, 1'b0, 16'hBEEF, 64'h0);
    // cmd_valid is still high: the pending WRITE must go in on the very next edge.
    @(posedge clk);
    #1 chk("after_hs_accept_pre", PRE_SRAM, 1'b1);
    chk("after_hs_accept_busy", busy, 1'b1);
    @(negedge clk);
    cmd_valid = 1'b0;
    while (!rsp_valid && checks < 100000) @(negedge clk);
    chk("after_hs_wdone", rsp_valid, 1'b1);
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;

    run_cmd("compute_a50f", 2'b10, 4'd9, 16'h0, 16'hA50F, 16'h0, 64'hFEDC_BA98_7654_3210,
            0, 1'b0, 9, 2, 6, 0, 0, 16'hA50F, 16'h5AF0, 16'h0, 1'b0, 16'h0,
            64'hFEDC_BA98_7654_3210);
    run_cmd("write_r5", 2'b00, 4'd5, 16'h0F0F, 16'h0, 16'h0, 64'h0, 2, 1'b0,
            5, 2, 0, 0, 2, 16'h0020, 16'h0, 16'h0F0F, 1'b0, 16'h0, 64'h0);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
